// File: rtl/seq_arb_4in_requester.sv
// seq_arb_4in_requester: per-client pending counters driving arbiter reqs, grant checking, round-robin priority feedback
module seq_arb_4in_requester #(
    parameter int CNT_WIDTH = 3,
    parameter bit RR_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] push,
    output logic [3:0] push_rdy,
    output logic [3:0] reqs,
    input  logic [3:0] grants,
    output logic       set_priority_en,
    output logic [3:0] set_priority,
    output logic       idle,
    output logic [7:0] grant_total,
    output logic       err
);
    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    logic [CNT_WIDTH-1:0] cnt [4];
    logic onehot, valid, bad;
    assign onehot = (grants != 4'd0) && ((grants & (grants - 4'd1)) == 4'd0);
    assign valid  = onehot && ((grants & reqs) != 4'd0);
    assign bad    = (grants != 4'd0) && !valid;
    assign idle   = reqs == 4'd0;
    for (genvar i = 0; i < 4; i++) begin : g_port
        logic inc, dec;
        assign reqs[i]     = cnt[i] != '0;
        assign push_rdy[i] = cnt[i] != MAX;
        assign inc = push[i] && push_rdy[i];
        assign dec = valid && grants[i];
        always_ff @(posedge clk) begin
            if (reset)
                cnt[i] <= '0;
            else if (inc && !dec)
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            else if (dec && !inc)
                cnt[i] <= cnt[i] - CNT_WIDTH'(1);
        end
    end
    // next priority is the port just past the winner, wrapping 3 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            set_priority_en <= 1'b0;
            set_priority    <= 4'b0001;
            grant_total     <= 8'd0;
            err             <= 1'b0;
        end else begin
            set_priority_en <= RR_EN && valid;
            if (RR_EN && valid)
                set_priority <= {grants[2:0], grants[3]};
            grant_total <= grant_total + {7'd0, valid};
            err         <= err || bad;
        end
    end
endmodule
